// File: rtl/secuenciador_melodia_pkg.sv
`default_nettype none
// ============================================================================
// Module      : melodia_pkg
// Description : Shared types and defaults for the melody sequencer: the FSM
//               state encoding, default ROM geometry, the reference clock
//               rate and a helper that sizes the duration counter.
// Revision    : 1.0 - initial release
// ============================================================================
package melodia_pkg;

  // REPOSO = idle, SONANDO = note sounding, SILENCIO = gap after a note
  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    SONANDO  = 2'd1,
    SILENCIO = 2'd2
  } estado_t;

  localparam int F_CLK          = 12000000;
  localparam int NUM_NOTAS_DEF  = 25;
  localparam int ANCHO_DIR_DEF  = 5;
  localparam int ANCHO_FREC_DEF = 16;

  // Width that holds 0..max(a,b)-1; never narrower than one bit.
  function automatic int ancho_contador(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/secuenciador_melodia_if.sv
`default_nettype none
// ============================================================================
// Module      : secuenciador_melodia_if
// Description : Control / ROM / audio bundle of the melody sequencer.
//   iniciar, detener    one-cycle start / stop pulses
//   repetir             level, loop the melody after the last note
//   frecuencia_de_nota  ROM word (half-period in clk cycles) for direccion_nota
//   direccion_nota      ROM address
//   salida_audio        square wave to the buzzer
//   reproduciendo       high while playing
//   fin_cancion         one-cycle pulse at the end of a non-looping pass
//   master: controls + ROM side, slave: the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface secuenciador_melodia_if
  import melodia_pkg::*;
#(
  parameter int ANCHO_DIR  = ANCHO_DIR_DEF,
  parameter int ANCHO_FREC = ANCHO_FREC_DEF
);
  logic                  iniciar;
  logic                  detener;
  logic                  repetir;
  logic [ANCHO_FREC-1:0] frecuencia_de_nota;
  logic [ANCHO_DIR-1:0]  direccion_nota;
  logic                  salida_audio;
  logic                  reproduciendo;
  logic                  fin_cancion;

  modport master (
    output iniciar, detener, repetir, frecuencia_de_nota,
    input  direccion_nota, salida_audio, reproduciendo, fin_cancion
  );

  modport slave (
    input  iniciar, detener, repetir, frecuencia_de_nota,
    output direccion_nota, salida_audio, reproduciendo, fin_cancion
  );
endinterface
`default_nettype wire

// File: rtl/secuenciador_melodia_generador_tono.sv
`default_nettype none
// ============================================================================
// Module      : generador_tono
// Description : Square-wave generator. A counter runs 0..semiperiodo-1 and the
//               output toggles on the wrap, so the period is 2*semiperiodo.
//               semiperiodo=0 is a rest (output low). Counter and output are
//               cleared whenever habilitar is low.
//   clk, rst_n   clock, asynchronous active-low reset
//   habilitar    run enable; low clears the generator
//   semiperiodo  half-period in clk cycles
//   salida       registered square wave
// Revision    : 1.0 - initial release
// ============================================================================
module generador_tono
  import melodia_pkg::*;
#(
  parameter int ANCHO_FREC = ANCHO_FREC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  habilitar,
  input  logic [ANCHO_FREC-1:0] semiperiodo,
  output logic                  salida
);

  logic [ANCHO_FREC-1:0] r_cont;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cont <= '0;
      salida <= 1'b0;
    end else if (!habilitar || (semiperiodo == '0)) begin
      r_cont <= '0;
      salida <= 1'b0;
    end else if (r_cont == (semiperiodo - 1'b1)) begin
      r_cont <= '0;
      salida <= ~salida;
    end else begin
      r_cont <= r_cont + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/secuenciador_melodia.sv
`default_nettype none
// ============================================================================
// Module      : secuenciador_melodia
// Description : Steps the note ROM address 0..NUM_NOTAS-1, holding each note
//               DUR_NOTA cycles followed by DUR_SILENCIO cycles of silence,
//               and drives the buzzer with the note's square wave.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         slave side of secuenciador_melodia_if (controls, ROM, audio)
// Revision    : 1.0 - initial release
// ============================================================================
module secuenciador_melodia
  import melodia_pkg::*;
#(
  parameter int NUM_NOTAS    = NUM_NOTAS_DEF,
  parameter int ANCHO_DIR    = ANCHO_DIR_DEF,
  parameter int ANCHO_FREC   = ANCHO_FREC_DEF,
  parameter int DUR_NOTA     = F_CLK / 4,
  parameter int DUR_SILENCIO = F_CLK / 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  secuenciador_melodia_if.slave   bus
);

  localparam int ANCHO_DUR = ancho_contador(DUR_NOTA, DUR_SILENCIO);

  localparam logic [ANCHO_DUR-1:0] c_fin_nota = ANCHO_DUR'(DUR_NOTA - 1);
  // Only meaningful when DUR_SILENCIO > 0; SILENCIO is unreachable otherwise.
  localparam logic [ANCHO_DUR-1:0] c_fin_sil  = ANCHO_DUR'(DUR_SILENCIO - 1);
  localparam logic [ANCHO_DIR-1:0] c_ultima   = ANCHO_DIR'(NUM_NOTAS - 1);

  estado_t                r_estado;
  logic [ANCHO_DUR-1:0]   r_cont;
  logic [ANCHO_DIR-1:0]   r_dir;
  logic                   r_reproduciendo;
  logic                   r_fin_cancion;
  logic                   w_fin_nota;
  logic                   w_fin_sil;
  logic                   w_avanzar;
  logic                   w_habilitar;
  logic                   w_audio;

  assign w_fin_nota = (r_estado == SONANDO)  && (r_cont == c_fin_nota);
  assign w_fin_sil  = (r_estado == SILENCIO) && (r_cont == c_fin_sil);
  // With no gap the note end is itself the advance point.
  assign w_avanzar  = w_fin_sil || (w_fin_nota && (DUR_SILENCIO == 0));

  // Dropping the enable on the last note cycle (or on a stop) clears the tone
  // flop at the same edge that leaves the note, so the following cycle starts
  // from a low output and a zero tone count.
  assign w_habilitar = (r_estado == SONANDO) && !w_fin_nota && !bus.detener;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado        <= REPOSO;
      r_cont          <= '0;
      r_dir           <= '0;
      r_reproduciendo <= 1'b0;
      r_fin_cancion   <= 1'b0;
    end else begin
      r_fin_cancion <= 1'b0;
      if (bus.detener) begin
        r_estado        <= REPOSO;
        r_cont          <= '0;
        r_dir           <= '0;
        r_reproduciendo <= 1'b0;
      end else if (w_avanzar) begin
        r_cont <= '0;
        if (r_dir != c_ultima) begin
          r_dir    <= r_dir + 1'b1;
          r_estado <= SONANDO;
        end else if (bus.repetir) begin
          r_dir    <= '0;
          r_estado <= SONANDO;
        end else begin
          r_dir           <= '0;
          r_estado        <= REPOSO;
          r_reproduciendo <= 1'b0;
          r_fin_cancion   <= 1'b1;
        end
      end else begin
        case (r_estado)
          REPOSO: begin
            if (bus.iniciar) begin
              r_estado        <= SONANDO;
              r_cont          <= '0;
              r_dir           <= '0;
              r_reproduciendo <= 1'b1;
            end
          end
          SONANDO: begin
            if (w_fin_nota) begin
              r_cont   <= '0;
              r_estado <= SILENCIO;
            end else begin
              r_cont <= r_cont + 1'b1;
            end
          end
          SILENCIO: begin
            r_cont <= r_cont + 1'b1;
          end
          default: begin
            r_estado <= REPOSO;
          end
        endcase
      end
    end
  end

  generador_tono #(
    .ANCHO_FREC (ANCHO_FREC)
  ) u_tono (
    .clk         (clk),
    .rst_n       (rst_n),
    .habilitar   (w_habilitar),
    .semiperiodo (bus.frecuencia_de_nota),
    .salida      (w_audio)
  );

  assign bus.direccion_nota = r_dir;
  assign bus.salida_audio   = w_audio;
  assign bus.reproduciendo  = r_reproduciendo;
  assign bus.fin_cancion    = r_fin_cancion;

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_melodia.sv
`default_nettype none
// ============================================================================
// Module      : tb_secuenciador_melodia
// Description : Self-checking bench for secuenciador_melodia with a 3-note
//               stub ROM {4,3,0}, DUR_NOTA=12. Instance a uses a 2-cycle gap,
//               instance b plays notes back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_secuenciador_melodia;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  secuenciador_melodia_if #(.ANCHO_DIR(5), .ANCHO_FREC(16)) bus_a ();
  secuenciador_melodia_if #(.ANCHO_DIR(5), .ANCHO_FREC(16)) bus_b ();

  secuenciador_melodia #(
    .NUM_NOTAS(3), .ANCHO_DIR(5), .ANCHO_FREC(16), .DUR_NOTA(12), .DUR_SILENCIO(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  secuenciador_melodia #(
    .NUM_NOTAS(3), .ANCHO_DIR(5), .ANCHO_FREC(16), .DUR_NOTA(12), .DUR_SILENCIO(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  function automatic logic [15:0] rom(input logic [4:0] dir);
    case (dir)
      5'd0:    return 16'd4;
      5'd1:    return 16'd3;
      default: return 16'd0;
    endcase
  endfunction

  assign bus_a.frecuencia_de_nota = rom(bus_a.direccion_nota);
  assign bus_b.frecuencia_de_nota = rom(bus_b.direccion_nota);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   ciclo;
    logic [4:0] dir;
    logic audio;
    logic repro;
    logic fin;
  } vec_t;

  localparam int N_VEC = 22;
  vec_t tabla [N_VEC];

  task automatic chk(input string nombre, input int actual, input int esperado);
    checks++;
    if (actual != esperado) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nombre, $time, actual, esperado);
    end
  endtask

  task automatic paso();
    @(posedge clk);
    #1;
  endtask

  task automatic arrancar_a();
    bus_a.iniciar = 1'b1;
    paso();
    bus_a.iniciar = 1'b0;
  endtask

  task automatic chk_a(input string n, input int dir, input int audio, input int repro, input int fin);
    chk({n, ".dir"},   int'(bus_a.direccion_nota), dir);
    chk({n, ".audio"}, int'(bus_a.salida_audio),   audio);
    chk({n, ".repro"}, int'(bus_a.reproduciendo),  repro);
    chk({n, ".fin"},   int'(bus_a.fin_cancion),    fin);
  endtask

  initial begin
    int fines;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_a.iniciar = 1'b0; bus_a.detener = 1'b0; bus_a.repetir = 1'b0;
    bus_b.iniciar = 1'b0; bus_b.detener = 1'b0; bus_b.repetir = 1'b0;

    // Expected single pass, cycle 0 = first cycle after the iniciar edge.
    tabla[0]  = '{0,  5'd0, 1'b0, 1'b1, 1'b0};
    tabla[1]  = '{3,  5'd0, 1'b0, 1'b1, 1'b0};
    tabla[2]  = '{4,  5'd0, 1'b1, 1'b1, 1'b0};
    tabla[3]  = '{7,  5'd0, 1'b1, 1'b1, 1'b0};
    tabla[4]  = '{8,  5'd0, 1'b0, 1'b1, 1'b0};
    tabla[5]  = '{11, 5'd0, 1'b0, 1'b1, 1'b0};
    tabla[6]  = '{12, 5'd0, 1'b0, 1'b1, 1'b0};
    tabla[7]  = '{13, 5'd0, 1'b0, 1'b1, 1'b0};
    tabla[8]  = '{14, 5'd1, 1'b0, 1'b1, 1'b0};
    tabla[9]  = '{16, 5'd1, 1'b0, 1'b1, 1'b0};
    tabla[10] = '{17, 5'd1, 1'b1, 1'b1, 1'b0};
    tabla[11] = '{20, 5'd1, 1'b0, 1'b1, 1'b0};
    tabla[12] = '{23, 5'd1, 1'b1, 1'b1, 1'b0};
    tabla[13] = '{25, 5'd1, 1'b1, 1'b1, 1'b0};
    tabla[14] = '{26, 5'd1, 1'b0, 1'b1, 1'b0};
    tabla[15] = '{27, 5'd1, 1'b0, 1'b1, 1'b0};
    tabla[16] = '{28, 5'd2, 1'b0, 1'b1, 1'b0};
    tabla[17] = '{39, 5'd2, 1'b0, 1'b1, 1'b0};
    tabla[18] = '{40, 5'd2, 1'b0, 1'b1, 1'b0};
    tabla[19] = '{41, 5'd2, 1'b0, 1'b1, 1'b0};
    tabla[20] = '{42, 5'd0, 1'b0, 1'b0, 1'b1};
    tabla[21] = '{43, 5'd0, 1'b0, 1'b0, 1'b0};

    // Reset values, then release between clock edges.
    #23;
    chk_a("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    paso();
    chk_a("idle", 0, 0, 0, 0);

    // Full non-looping pass driven by the table.
    arrancar_a();
    fines = 0;
    for (int c = 0; c <= 43; c++) begin
      if (c > 0) paso();
      if (bus_a.fin_cancion) fines++;
      for (int k = 0; k < N_VEC; k++)
        if (tabla[k].ciclo == c)
          chk_a($sformatf("pasada_c%0d", c), int'(tabla[k].dir), int'(tabla[k].audio),
                int'(tabla[k].repro), int'(tabla[k].fin));
      if (c >= 28 && c <= 39) chk("nota_p0_audio", int'(bus_a.salida_audio), 0);
    end
    chk("pulsos_fin", fines, 1);

    // Looping pass, then repetir dropped mid-way through the second pass.
    bus_a.repetir = 1'b1;
    arrancar_a();
    fines = 0;
    for (int c = 1; c <= 84; c++) begin
      paso();
      if (c == 47) bus_a.repetir = 1'b0;
      if (bus_a.fin_cancion) fines++;
      if (c == 42) chk_a("bucle_c42", 0, 0, 1, 0);
      if (c == 56) chk_a("bucle_c56", 1, 0, 1, 0);
      if (c == 83) chk_a("bucle_c83", 2, 0, 1, 0);
      if (c == 84) chk_a("bucle_c84", 0, 0, 0, 1);
    end
    chk("bucle_pulsos_fin", fines, 1);

    // Stop at cycle 5 of note 1 while the tone is high.
    arrancar_a();
    for (int c = 1; c <= 19; c++) paso();
    chk_a("pre_detener", 1, 1, 1, 0);
    bus_a.detener = 1'b1;
    paso();
    bus_a.detener = 1'b0;
    chk_a("detener", 0, 0, 0, 0);
    paso();
    chk_a("detener_sig", 0, 0, 0, 0);

    // iniciar and detener together from idle: stays idle.
    bus_a.iniciar = 1'b1;
    bus_a.detener = 1'b1;
    paso();
    bus_a.iniciar = 1'b0;
    bus_a.detener = 1'b0;
    chk_a("ini_det", 0, 0, 0, 0);
    paso();
    chk_a("ini_det_sig", 0, 0, 0, 0);

    // iniciar re-pulsed during note 1 is ignored.
    arrancar_a();
    for (int c = 1; c <= 42; c++) begin
      if (c == 16) bus_a.iniciar = 1'b1;
      paso();
      bus_a.iniciar = 1'b0;
      if (c == 28) chk_a("reinicio_c28", 2, 0, 1, 0);
      if (c == 42) chk_a("reinicio_c42", 0, 0, 0, 1);
    end

    // No-gap build: 36-cycle pass, notes back-to-back.
    bus_b.iniciar = 1'b1;
    paso();
    bus_b.iniciar = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      paso();
      if (c == 11) chk("b_c11.dir", int'(bus_b.direccion_nota), 0);
      if (c == 12) chk("b_c12.dir", int'(bus_b.direccion_nota), 1);
      if (c == 15) chk("b_c15.audio", int'(bus_b.salida_audio), 1);
      if (c == 23) chk("b_c23.audio", int'(bus_b.salida_audio), 1);
      if (c == 24) chk("b_c24.dir", int'(bus_b.direccion_nota), 2);
      if (c == 24) chk("b_c24.audio", int'(bus_b.salida_audio), 0);
      if (c == 35) chk("b_c35.repro", int'(bus_b.reproduciendo), 1);
      if (c == 35) chk("b_c35.fin", int'(bus_b.fin_cancion), 0);
      if (c == 36) chk("b_c36.fin", int'(bus_b.fin_cancion), 1);
      if (c == 36) chk("b_c36.repro", int'(bus_b.reproduciendo), 0);
    end

    // Asynchronous reset in the middle of note 1 with the tone high.
    arrancar_a();
    for (int c = 1; c <= 18; c++) paso();
    chk_a("pre_reset", 1, 1, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_a("reset_async", 0, 0, 0, 0);
    #3;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) paso();
    chk_a("post_reset", 0, 0, 0, 0);
    arrancar_a();
    chk_a("post_reset_ini", 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
